gray_tick_ctrl: RTL and testbench

- Run/stop/step controller for the 1 s gray-code second counter datapath: owns the tick prescaler, the binary count and the registered gray output.
- Accepts a small valid/ready command interface so higher-level logic can start, stop, single-step, preload, clear and reverse the count.
- Sits between the board control logic and the display/LED logic that consumes o_gray.

---
 rtl/gray_tick_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_gray_tick_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_tick_ctrl.sv
// gray_tick_ctrl: run/stop/step controller for the gray-code second counter.
// Owns the tick prescaler, the binary count and the registered gray output.
// A valid/ready port accepts commands, at most one every two cycles.
// Optional feature: define GRAY_TICK_CTRL_ONESHOT_EN to make a running count
// saturate at its end value, pulse o_done and fall back to IDLE.
//
// state  | meaning
// S_IDLE | stopped; only commands change the count
// S_RUN  | prescaler counting, one step per tick
module gray_tick_ctrl #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int WIDTH       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_data,
  output logic [WIDTH-1:0] o_gray,
  output logic [WIDTH-1:0] o_bin,
  output logic             o_upd,
  output logic             o_wrap,
  output logic             o_running,
  output logic             o_dir,
  output logic             o_done
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] BIN_MAX  = '1;

  localparam logic [2:0] OP_START    = 3'd1;
  localparam logic [2:0] OP_STOP     = 3'd2;
  localparam logic [2:0] OP_STEP     = 3'd3;
  localparam logic [2:0] OP_LOAD     = 3'd4;
  localparam logic [2:0] OP_DIR_UP   = 3'd5;
  localparam logic [2:0] OP_DIR_DOWN = 3'd6;
  localparam logic [2:0] OP_CLEAR    = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             dir_q, dir_d;
  logic             upd_q, upd_d;
  logic             wrap_q, wrap_d;
  logic             running_q, running_d;
  logic             ready_q, ready_d;
  logic             accept, tick, step_en, step_wrap;
  logic [WIDTH-1:0] step_val;

`ifdef GRAY_TICK_CTRL_ONESHOT_EN
  logic done_q, done_d;
`endif

  assign accept = i_cmd_valid & ready_q;
  assign tick   = (state_q == S_RUN) && (presc_q == PRESC_TC);

  // Next-state: prescaler, command decode, tick step and their precedence.
  always_comb begin
    state_d   = state_q;
    presc_d   = '0;
    bin_d     = bin_q;
    dir_d     = dir_q;
    upd_d     = 1'b0;
    wrap_d    = 1'b0;
    ready_d   = ~accept;
    step_en   = tick;
`ifdef GRAY_TICK_CTRL_ONESHOT_EN
    done_d    = 1'b0;
`endif
    if (state_q == S_RUN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    step_wrap = dir_q ? (bin_q == BIN_MAX) : (bin_q == '0);
    step_val  = dir_q ? bin_q + 1'b1 : bin_q - 1'b1;

    if (accept) begin
      case (i_cmd_op)
        OP_START: begin
          state_d = S_RUN;
          presc_d = '0;
          step_en = 1'b0;
        end
        OP_STOP: begin
          if (state_q == S_RUN) begin
            state_d = S_IDLE;
            presc_d = '0;
            step_en = 1'b0;
          end
        end
        OP_STEP: begin
          if (state_q == S_IDLE) step_en = 1'b1;
        end
        OP_LOAD: begin
          step_en = 1'b0;
          bin_d   = i_cmd_data;
          upd_d   = 1'b1;
        end
        OP_DIR_UP:   dir_d = 1'b1;
        OP_DIR_DOWN: dir_d = 1'b0;
        OP_CLEAR: begin
          step_en = 1'b0;
          bin_d   = '0;
          presc_d = '0;
          upd_d   = 1'b1;
        end
        default: ;
      endcase
    end

    if (step_en) begin
`ifdef GRAY_TICK_CTRL_ONESHOT_EN
      // A running count stops at its end value instead of wrapping.
      if ((state_q == S_RUN) && step_wrap) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        presc_d = '0;
      end else begin
        bin_d  = step_val;
        upd_d  = 1'b1;
        wrap_d = step_wrap;
      end
`else
      bin_d  = step_val;
      upd_d  = 1'b1;
      wrap_d = step_wrap;
`endif
    end

    gray_d    = bin_d ^ (bin_d >> 1);
    running_d = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      bin_q     <= '0;
      gray_q    <= '0;
      dir_q     <= 1'b1;
      upd_q     <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      dir_q     <= dir_d;
      upd_q     <= upd_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
      ready_q   <= ready_d;
    end
  end

`ifdef GRAY_TICK_CTRL_ONESHOT_EN
  // Terminal pulse register for the one-shot mode.
  always_ff @(posedge i_clk) begin
    if (i_rst) done_q <= 1'b0;
    else       done_q <= done_d;
  end
  assign o_done = done_q;
`else
  assign o_done = 1'b0;
`endif

  assign o_cmd_ready = ready_q;
  assign o_gray      = gray_q;
  assign o_bin       = bin_q;
  assign o_upd       = upd_q;
  assign o_wrap      = wrap_q;
  assign o_running   = running_q;
  assign o_dir       = dir_q;

endmodule

// File: tb/tb_gray_tick_ctrl.sv
// Directed bench for gray_tick_ctrl with TICK_DIV = 10.
module tb_gray_tick_ctrl;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_START    = 3'd1;
  localparam logic [2:0] OP_STOP     = 3'd2;
  localparam logic [2:0] OP_STEP     = 3'd3;
  localparam logic [2:0] OP_LOAD     = 3'd4;
  localparam logic [2:0] OP_DIR_UP   = 3'd5;
  localparam logic [2:0] OP_DIR_DOWN = 3'd6;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cmd_valid = 1'b0;
  logic [2:0] i_cmd_op = 3'd0;
  logic [3:0] i_cmd_data = 4'd0;
  logic       o_cmd_ready;
  logic [3:0] o_gray, o_bin;
  logic       o_upd, o_wrap, o_running, o_dir, o_done;

  int vectors = 0;
  int errors  = 0;

  gray_tick_ctrl #(.CLK_FREQ_HZ(10), .TICK_HZ(1), .WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_data(i_cmd_data),
    .o_gray(o_gray), .o_bin(o_bin), .o_upd(o_upd), .o_wrap(o_wrap),
    .o_running(o_running), .o_dir(o_dir), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic step_clk();
    @(posedge i_clk);
    #1;
  endtask

  // Waits (bounded) for ready, then presents one command for one accept edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] data);
    int n = 0;
    while (o_cmd_ready !== 1'b1 && n < 8) begin
      step_clk();
      n++;
    end
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready op=%0d: ready=%b required 1", op, o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_data  = data;
    step_clk();
    i_cmd_valid = 1'b0;
    i_cmd_op    = OP_NOP;
  endtask

  // Advances until o_upd is seen (bounded); returns the number of edges.
  task automatic wait_upd(output int edges);
    edges = 0;
    do begin
      step_clk();
      edges++;
    end while (o_upd !== 1'b1 && edges < 40);
    vectors++;
    if (o_upd !== 1'b1) begin
      errors++;
      $display("FAIL wait_upd: no o_upd within %0d cycles", edges);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    step_clk();
    step_clk();
    vectors++;
    if ({o_bin, o_gray, o_dir, o_upd, o_wrap, o_running, o_cmd_ready, o_done} !==
        {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_vals: bin=%0d gray=%b dir=%b upd=%b wrap=%b run=%b rdy=%b done=%b required 0 0000 1 0 0 0 0 0",
               o_bin, o_gray, o_dir, o_upd, o_wrap, o_running, o_cmd_ready, o_done);
    end
    i_rst = 1'b0;
    step_clk();
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b required 1", o_cmd_ready);
    end
  endtask

  task automatic test_run();
    logic [3:0] gexp [4];
    gexp = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
    issue(OP_START, 4'd0);
    vectors++;
    if ({o_running, o_upd, o_bin} !== {1'b1, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL start: run=%b upd=%b bin=%0d required 1 0 0", o_running, o_upd, o_bin);
    end
    for (int k = 1; k <= 3; k++) begin
      for (int c = 1; c <= 9; c++) begin
        step_clk();
        vectors++;
        if (o_upd !== 1'b0) begin
          errors++;
          $display("FAIL early_upd step=%0d cycle=%0d: upd=%b required 0", k, c, o_upd);
        end
      end
      step_clk();
      vectors++;
      if ({o_upd, o_bin, o_gray} !== {1'b1, 4'(k), gexp[k]}) begin
        errors++;
        $display("FAIL run_step %0d: upd=%b bin=%0d gray=%b required 1 %0d %b",
                 k, o_upd, o_bin, o_gray, k, gexp[k]);
      end
    end
  endtask

  task automatic test_load_wrap();
    int n;
    issue(OP_LOAD, 4'd15);
    vectors++;
    if ({o_upd, o_wrap, o_bin, o_gray} !== {1'b1, 1'b0, 4'd15, 4'b1000}) begin
      errors++;
      $display("FAIL load15: upd=%b wrap=%b bin=%0d gray=%b required 1 0 15 1000",
               o_upd, o_wrap, o_bin, o_gray);
    end
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray, o_wrap} !== {8'd9, 4'd0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL up_wrap: edges=%0d bin=%0d gray=%b wrap=%b required 9 0 0000 1",
               n, o_bin, o_gray, o_wrap);
    end
  endtask

  task automatic test_down();
    int n;
    issue(OP_STOP, 4'd0);
    vectors++;
    if ({o_running, o_bin} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL stop: run=%b bin=%0d required 0 0", o_running, o_bin);
    end
    issue(OP_DIR_DOWN, 4'd0);
    vectors++;
    if (o_dir !== 1'b0) begin
      errors++;
      $display("FAIL dir_down: dir=%b required 0", o_dir);
    end
    issue(OP_START, 4'd0);
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray, o_wrap} !== {8'd10, 4'd15, 4'b1000, 1'b1}) begin
      errors++;
      $display("FAIL down_wrap: edges=%0d bin=%0d gray=%b wrap=%b required 10 15 1000 1",
               n, o_bin, o_gray, o_wrap);
    end
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray, o_wrap} !== {8'd10, 4'd14, 4'b1001, 1'b0}) begin
      errors++;
      $display("FAIL down_step: edges=%0d bin=%0d gray=%b wrap=%b required 10 14 1001 0",
               n, o_bin, o_gray, o_wrap);
    end
  endtask

  task automatic test_stop_on_tick();
    int n;
    issue(OP_DIR_UP, 4'd0);
    issue(OP_LOAD, 4'd4);
    vectors++;
    if ({o_bin, o_gray, o_dir} !== {4'd4, 4'b0110, 1'b1}) begin
      errors++;
      $display("FAIL load4: bin=%0d gray=%b dir=%b required 4 0110 1", o_bin, o_gray, o_dir);
    end
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray} !== {8'd7, 4'd5, 4'b0111}) begin
      errors++;
      $display("FAIL step_to5: edges=%0d bin=%0d gray=%b required 7 5 0111", n, o_bin, o_gray);
    end
    for (int c = 0; c < 9; c++) step_clk();
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_tick: ready=%b required 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_op    = OP_STOP;
    step_clk();
    i_cmd_valid = 1'b0;
    i_cmd_op    = OP_NOP;
    vectors++;
    if ({o_running, o_upd, o_bin} !== {1'b0, 1'b0, 4'd5}) begin
      errors++;
      $display("FAIL stop_on_tick: run=%b upd=%b bin=%0d required 0 0 5", o_running, o_upd, o_bin);
    end
    issue(OP_STEP, 4'd0);
    vectors++;
    if ({o_upd, o_wrap, o_bin, o_gray} !== {1'b1, 1'b0, 4'd6, 4'b0101}) begin
      errors++;
      $display("FAIL idle_step: upd=%b wrap=%b bin=%0d gray=%b required 1 0 6 0101",
               o_upd, o_wrap, o_bin, o_gray);
    end
  endtask

  task automatic test_back_to_back();
    step_clk();
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready0: ready=%b required 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1;
    i_cmd_op    = OP_START;
    step_clk();
    i_cmd_op    = OP_DIR_DOWN;
    vectors++;
    if ({o_cmd_ready, o_running} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: ready=%b run=%b required 0 1", o_cmd_ready, o_running);
    end
    step_clk();
    vectors++;
    if ({o_cmd_ready, o_dir} !== {1'b1, 1'b1}) begin
      errors++;
      $display("FAIL b2b_gap: ready=%b dir=%b required 1 1", o_cmd_ready, o_dir);
    end
    step_clk();
    i_cmd_valid = 1'b0;
    i_cmd_op    = OP_NOP;
    vectors++;
    if ({o_cmd_ready, o_dir} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: ready=%b dir=%b required 0 0", o_cmd_ready, o_dir);
    end
    step_clk();
    step_clk();
    i_rst = 1'b1;
    step_clk();
    vectors++;
    if ({o_bin, o_gray, o_dir, o_upd, o_wrap, o_running, o_cmd_ready, o_done} !==
        {4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: bin=%0d gray=%b dir=%b upd=%b wrap=%b run=%b rdy=%b done=%b required 0 0000 1 0 0 0 0 0",
               o_bin, o_gray, o_dir, o_upd, o_wrap, o_running, o_cmd_ready, o_done);
    end
    i_rst = 1'b0;
    step_clk();
  endtask

  task automatic test_end_of_count();
    int n;
    issue(OP_LOAD, 4'd14);
    issue(OP_START, 4'd0);
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray} !== {8'd10, 4'd15, 4'b1000}) begin
      errors++;
      $display("FAIL eoc_step: edges=%0d bin=%0d gray=%b required 10 15 1000", n, o_bin, o_gray);
    end
`ifdef GRAY_TICK_CTRL_ONESHOT_EN
    for (int c = 0; c < 10; c++) step_clk();
    vectors++;
    if ({o_done, o_bin, o_running, o_wrap, o_upd} !== {1'b1, 4'd15, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL oneshot_done: done=%b bin=%0d run=%b wrap=%b upd=%b required 1 15 0 0 0",
               o_done, o_bin, o_running, o_wrap, o_upd);
    end
    step_clk();
    vectors++;
    if ({o_done, o_bin} !== {1'b0, 4'd15}) begin
      errors++;
      $display("FAIL oneshot_pulse: done=%b bin=%0d required 0 15", o_done, o_bin);
    end
`else
    wait_upd(n);
    vectors++;
    if ({8'(n), o_bin, o_gray, o_wrap, o_done} !== {8'd10, 4'd0, 4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL modulo_wrap: edges=%0d bin=%0d gray=%b wrap=%b done=%b required 10 0 0000 1 0",
               n, o_bin, o_gray, o_wrap, o_done);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_wrap();
    test_down();
    test_stop_on_tick();
    test_back_to_back();
    test_end_of_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
